// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: latches a word on a start edge and shifts it out LSB-first
// framed by one start bit and STOP_BITS stop bits, with busy/done/overrun status.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 32'd868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_pulse_i,
  input  logic [DATA_BITS-1:0] data_in_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overrun_o
);

  localparam int unsigned      CntW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [31:0]      BitLast  = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0]      StopLast = 32'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  DataLast = CntW'(DATA_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                state_q;
  logic                  start_prev_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [31:0]           div_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  overrun_q;

  logic start_edge;
  logic accept;

  assign start_edge = start_pulse_i & ~start_prev_q;
  // The done cycle still belongs to the finishing frame, so an edge there is refused.
  assign accept     = start_edge && (state_q == StIdle) && !done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      div_q        <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      start_prev_q <= start_pulse_i;
      done_q       <= 1'b0;
      overrun_q    <= start_edge & ~accept;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shift_q <= data_in_i;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            div_q   <= '0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (div_q == BitLast) begin
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
            div_q     <= '0;
            state_q   <= StData;
          end else begin
            div_q <= div_q + 32'd1;
          end
        end
        StData: begin
          if (div_q == BitLast) begin
            div_q <= '0;
            if (bit_cnt_q == DataLast) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + CntW'(1);
              tx_q      <= shift_q[1];
            end
          end else begin
            div_q <= div_q + 32'd1;
          end
        end
        StStop: begin
          if (div_q == StopLast) begin
            div_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            div_q <= div_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: whole-waveform captures compared against
// hand-built frame patterns (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 and 2).
module tb_uart_tx_serializer;

  localparam int unsigned Cpb  = 4;
  localparam int          NCyc = 96;

  logic       clk;
  logic       rst_n;
  logic       start, start2;
  logic [7:0] data, data2;
  logic       tx, busy, done, overrun;
  logic       tx2, busy2, done2, overrun2;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_serializer #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .STOP_BITS(1)) u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_pulse_i (start),
    .data_in_i     (data),
    .tx_o          (tx),
    .busy_o        (busy),
    .done_o        (done),
    .overrun_o     (overrun)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .STOP_BITS(2)) u_dut2 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_pulse_i (start2),
    .data_in_i     (data2),
    .tx_o          (tx2),
    .busy_o        (busy2),
    .done_o        (done2),
    .overrun_o     (overrun2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected line: frame bits fr[0..nb-1] in send order, each held Cpb cycles from sample 'first'.
  function automatic logic [127:0] wave(input logic [11:0] fr, input int nb, input int first);
    logic [127:0] w;
    w = '1;
    for (int k = 0; k < nb; k++)
      for (int c = 0; c < int'(Cpb); c++)
        w[first + k * int'(Cpb) + c] = fr[k];
    return w;
  endfunction

  function automatic logic [127:0] span(input int first, input int len);
    logic [127:0] w;
    w = '0;
    for (int i = first; i < first + len; i++) w[i] = 1'b1;
    return w;
  endfunction

  function automatic logic [127:0] at(input int p);
    logic [127:0] one;
    one = 128'd1;
    return one << p;
  endfunction

  // sp[i] is the start level seen at posedge i; sample i is taken on the negedge after it.
  task automatic capture(input bit sel, input logic [127:0] sp, input logic [7:0] d,
                         input logic [7:0] d_later, output logic [127:0] txw,
                         output logic [127:0] bw, output logic [127:0] dw,
                         output logic [127:0] ow);
    if (sel) data2 = d; else data = d;
    for (int i = 0; i < NCyc; i++) begin
      if (sel) start2 = sp[i]; else start = sp[i];
      @(negedge clk);
      if (i == 0) begin
        if (sel) data2 = d_later; else data = d_later;
      end
      txw[i] = sel ? tx2 : tx;
      bw[i]  = sel ? busy2 : busy;
      dw[i]  = sel ? done2 : done;
      ow[i]  = sel ? overrun2 : overrun;
    end
    for (int i = NCyc; i < 128; i++) begin
      txw[i] = 1'b1; bw[i] = 1'b0; dw[i] = 1'b0; ow[i] = 1'b0;
    end
    if (sel) start2 = 1'b0; else start = 1'b0;
  endtask

  logic [127:0] txw, bw, dw, ow;

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; data = 8'h00; data2 = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset_tx",      {127'd0, tx},      128'd1);
    check_eq("reset_busy",    {127'd0, busy},    128'd0);
    check_eq("reset_done",    {127'd0, done},    128'd0);
    check_eq("reset_overrun", {127'd0, overrun}, 128'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single frame A5 -> line 0,1,0,1,0,0,1,0,1,1
    capture(1'b0, at(0), 8'hA5, 8'hA5, txw, bw, dw, ow);
    check_eq("t1_tx",   txw, wave({1'b1, 8'hA5, 1'b0}, 10, 0));
    check_eq("t1_busy", bw,  span(0, 40));
    check_eq("t1_done", dw,  at(40));
    check_eq("t1_ovr",  ow,  128'd0);

    // 2: start held 6 cycles, data 00
    capture(1'b0, span(0, 6), 8'h00, 8'h00, txw, bw, dw, ow);
    check_eq("t2_tx",   txw, ~span(0, 36));
    check_eq("t2_busy", bw,  span(0, 40));
    check_eq("t2_done", dw,  at(40));
    check_eq("t2_ovr",  ow,  128'd0);

    // 3: second edge at cycle 20; data_in changed after latch
    capture(1'b0, at(0) | at(20), 8'h3C, 8'hFF, txw, bw, dw, ow);
    check_eq("t3_tx",   txw, wave({1'b1, 8'h3C, 1'b0}, 10, 0));
    check_eq("t3_busy", bw,  span(0, 40));
    check_eq("t3_done", dw,  at(40));
    check_eq("t3_ovr",  ow,  at(20));

    // 4: reset during a low data bit, start held high through release
    data  = 8'h00;
    start = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("t4_pre_tx", {127'd0, tx}, 128'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t4_rst_tx",   {127'd0, tx},   128'd1);
    check_eq("t4_rst_busy", {127'd0, busy}, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture(1'b0, span(0, 8) | at(10), 8'h00, 8'h00, txw, bw, dw, ow);
    check_eq("t4_tx",   txw, wave({1'b1, 8'h00, 1'b0}, 10, 10));
    check_eq("t4_busy", bw,  span(10, 40));
    check_eq("t4_done", dw,  at(50));
    check_eq("t4_ovr",  ow,  128'd0);

    // 5a: edge the cycle after done -> second frame (FF) from sample 42
    capture(1'b0, at(0) | at(42), 8'h5A, 8'hFF, txw, bw, dw, ow);
    check_eq("t5a_tx",   txw, wave({1'b1, 8'h5A, 1'b0}, 10, 0) & wave({1'b1, 8'hFF, 1'b0}, 10, 42));
    check_eq("t5a_busy", bw,  span(0, 40) | span(42, 40));
    check_eq("t5a_done", dw,  at(40) | at(82));
    check_eq("t5a_ovr",  ow,  128'd0);

    // 5b: edge while done is high -> overrun, no frame
    capture(1'b0, at(0) | at(41), 8'h5A, 8'hFF, txw, bw, dw, ow);
    check_eq("t5b_tx",   txw, wave({1'b1, 8'h5A, 1'b0}, 10, 0));
    check_eq("t5b_busy", bw,  span(0, 40));
    check_eq("t5b_done", dw,  at(40));
    check_eq("t5b_ovr",  ow,  at(41));

    // 6: two stop bits, data 81
    capture(1'b1, at(0), 8'h81, 8'h81, txw, bw, dw, ow);
    check_eq("t6_tx",   txw, wave({2'b11, 8'h81, 1'b0}, 11, 0));
    check_eq("t6_busy", bw,  span(0, 44));
    check_eq("t6_done", dw,  at(44));
    check_eq("t6_ovr",  ow,  128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
